// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and defaults for the alu command sequencer
// Purpose: ALU opcode enum, default widths and the response record layout.
// Ports: none (package).
package alu_pkg;

  localparam int DW_DEF = 32;
  localparam int TW_DEF = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  // Response record at default widths; the FIFO stores exactly this packing
  // {y, tag, zero}, so its width is DW + TW + 1 for any parameterisation.
  typedef struct packed {
    logic [DW_DEF-1:0] y;
    logic [TW_DEF-1:0] tag;
    logic              zero;
  } alu_rsp_t;

  localparam int RSP_W = $bits(alu_rsp_t);

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational single-adder ALU driven by alu_seq
// Purpose: y = A op B, ADD/SUB wrap modulo 2^DW.
// Ports: A, B operands; alu_control opcode (alu_op_e encoding); y result.
module alu
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [1:0]    alu_control,
  output logic [DW-1:0] y
);

  always_comb begin
    y = '0;
    case (alu_op_e'(alu_control))
      ALU_ADD: y = A + B;
      ALU_SUB: y = A - B;
      ALU_AND: y = A & B;
      ALU_OR:  y = A | B;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_rsp_fifo.sv
// rtl/alu_rsp_fifo.sv - synchronous response FIFO for alu_seq
// Purpose: DEPTH-entry FIFO with registered count and head-of-queue output.
// Ports: clk, rst (sync, active high); push/din write; pop advances head;
//        head is the oldest entry; count is the occupancy (0..DEPTH).
module alu_rsp_fifo
  import alu_pkg::*;
#(
  parameter int W     = RSP_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is cleared on reset so the head reads as all-zero while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // The sequencer's credit check must make this unreachable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && count == (AW + 1)'(DEPTH)));
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - command sequencer and result collector for the alu
// Purpose: registers commands onto the external ALU, captures y one cycle
//          later and returns tagged results in order through a FIFO.
// Ports: clk, rst (sync, active high);
//        cmd_valid/cmd_ready/cmd_op/cmd_acc/cmd_a/cmd_b/cmd_tag command port;
//        alu_a/alu_b/alu_control to the ALU, alu_y from it;
//        rsp_valid/rsp_ready/rsp_y/rsp_tag/rsp_zero response port.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int TW    = TW_DEF,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  alu_op_e       cmd_op,
  input  logic          cmd_acc,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic [TW-1:0] cmd_tag,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_control,
  input  logic [DW-1:0] alu_y,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_y,
  output logic [TW-1:0] rsp_tag,
  output logic          rsp_zero
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = DW + TW + 1;

  logic          s1_valid;
  logic [TW-1:0] s1_tag;
  logic [DW-1:0] acc_q;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic [RW-1:0] push_data;
  logic [RW-1:0] head;
  logic          accept;
  logic          pop;
  logic [DW-1:0] op_a;

  // The op in stage 1 will occupy a FIFO slot next edge, so it is charged
  // against the credit now. Only registered state feeds cmd_ready.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid};
  assign cmd_ready   = credit_used < (CW + 1)'(DEPTH);
  assign accept      = cmd_valid & cmd_ready;

  // Accumulate: the newest result is still on alu_y while stage 1 is busy,
  // otherwise it has already been captured into acc_q.
  assign op_a = !cmd_acc ? cmd_a : (s1_valid ? alu_y : acc_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_tag      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= 2'b00;
      acc_q       <= '0;
    end else begin
      s1_valid <= accept;
      // Operand registers hold when idle so the ALU inputs do not toggle.
      if (accept) begin
        alu_a       <= op_a;
        alu_b       <= cmd_b;
        alu_control <= cmd_op;
        s1_tag      <= cmd_tag;
      end
      if (s1_valid) begin
        acc_q <= alu_y;
      end
    end
  end

  assign push_data = {alu_y, s1_tag, (alu_y == '0)};
  assign pop       = rsp_valid & rsp_ready;

  alu_rsp_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_valid),
    .din   (push_data),
    .pop   (pop),
    .head  (head),
    .count (fifo_count)
  );

  assign rsp_valid                   = (fifo_count != '0);
  assign {rsp_y, rsp_tag, rsp_zero}  = head;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with the external alu
module tb_alu_seq;
  import alu_pkg::*;

  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  alu_op_e       cmd_op;
  logic          cmd_acc;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic [TW-1:0] cmd_tag;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [1:0]    alu_control;
  logic [DW-1:0] alu_y;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_y;
  logic [TW-1:0] rsp_tag;
  logic          rsp_zero;

  always #5 clk = ~clk;

  alu_seq #(.DW(DW), .TW(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_acc(cmd_acc), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_tag(rsp_tag), .rsp_zero(rsp_zero)
  );

  alu #(.DW(DW)) u_alu (
    .A(alu_a), .B(alu_b), .alu_control(alu_control), .y(alu_y)
  );

  // Reference model: an ordered list of outstanding results plus the last
  // result computed since reset (the accumulator value).
  typedef struct {
    logic [DW-1:0] y;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] last_y;
  int            passed = 0;
  int            total  = 0;
  int            accepts = 0;
  int            pops    = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] y_prev;
  logic [TW-1:0] tag_prev;
  int            a0, p0;

  function automatic logic [DW-1:0] ref_op(alu_op_e op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(alu_op_e op, logic acc, logic [DW-1:0] a, logic [DW-1:0] b, logic [TW-1:0] tag);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_acc   = acc;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
    cmd_acc   = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven: predicts the
  // handshakes of the coming rising edge, checks responses, advances a cycle.
  task automatic tick();
    exp_t e;
    chk("cmd_ready_credit", cmd_ready, (q.size() < DEPTH));
    if (stall_prev) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_y", rsp_y, y_prev);
      chk("hold_tag", rsp_tag, tag_prev);
    end
    if (cmd_valid && cmd_ready) begin
      e.y   = ref_op(cmd_op, cmd_acc ? last_y : cmd_a, cmd_b);
      e.tag = cmd_tag;
      last_y = e.y;
      q.push_back(e);
      accepts++;
    end
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 0);
      end else begin
        e = q.pop_front();
        chk("rsp_y", rsp_y, e.y);
        chk("rsp_tag", rsp_tag, e.tag);
        chk("rsp_zero", rsp_zero, (e.y == 0));
      end
      pops++;
    end
    stall_prev = rsp_valid && !rsp_ready;
    y_prev     = rsp_y;
    tag_prev   = rsp_tag;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    last_y     = '0;
    stall_prev = 1'b0;
  endtask

  task automatic drain();
    idle();
    rsp_ready = 1'b1;
    repeat (DEPTH + 4) tick();
    chk("drain_rsp_valid", rsp_valid, 0);
    chk("drain_model_empty", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    cmd_op = ALU_ADD; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    idle();
    @(posedge clk);
    do_reset();

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_control", alu_control, 0);

    // Single ADD, latency 2
    rsp_ready = 1'b1;
    send(ALU_ADD, 1'b0, 32'd10, 32'd20, 4'd1);
    tick();
    idle();
    chk("add_lat1_valid", rsp_valid, 0);
    chk("add_alu_a", alu_a, 10);
    chk("add_alu_b", alu_b, 20);
    tick();
    chk("add_lat2_valid", rsp_valid, 1);
    chk("add_y", rsp_y, 30);
    chk("add_tag", rsp_tag, 1);
    chk("add_zero", rsp_zero, 0);
    tick();

    // Back-to-back ops, one result per cycle
    p0 = pops;
    send(ALU_SUB, 1'b0, 32'd0, 32'd5, 4'd2);  tick();
    send(ALU_AND, 1'b0, 32'd10, 32'd20, 4'd3); tick();
    chk("b2b_first_y", rsp_y, 32'hFFFF_FFFB);
    send(ALU_OR, 1'b0, 32'd10, 32'd20, 4'd4);  tick();
    send(ALU_ADD, 1'b0, 32'd0, 32'd0, 4'd5);   tick();
    chk("b2b_pops_mid", pops - p0, 2);
    idle();
    tick();
    chk("b2b_last_zero", rsp_zero, 1);
    tick();
    chk("b2b_pops_end", pops - p0, 4);
    drain();

    // Backpressure: six offered, four accepted
    rsp_ready = 1'b0;
    a0 = accepts;
    for (int i = 0; i < 6; i++) begin
      send(ALU_ADD, 1'b0, DW'(i * 3), DW'(i + 7), TW'(i + 6));
      tick();
    end
    chk("bp_accepts", accepts - a0, 4);
    chk("bp_ready_low", cmd_ready, 0);
    rsp_ready = 1'b1;
    tick();
    chk("bp_ready_after_pop", cmd_ready, 1);
    drain();

    // Accumulate chain: forwarding then acc_q path
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(ALU_ADD, 1'b1, $urandom, 32'd5, TW'(i));
      tick();
    end
    idle();
    tick();
    send(ALU_SUB, 1'b1, $urandom, 32'd20, 4'd9);
    tick();
    idle();
    tick();
    chk("acc_sub_y", rsp_y, 32'hFFFF_FFFB);
    drain();

    // Simultaneous push/pop with two entries held
    rsp_ready = 1'b0;
    send(ALU_OR, 1'b0, 32'h1, 32'h2, 4'd1); tick();
    send(ALU_OR, 1'b0, 32'h4, 32'h8, 4'd2); tick();
    idle();
    tick();
    rsp_ready = 1'b1;
    a0 = accepts;
    for (int i = 0; i < 10; i++) begin
      send(ALU_ADD, 1'b0, $urandom, $urandom, TW'(i));
      tick();
      chk("pp_ready", cmd_ready, 1);
    end
    chk("pp_accepts", accepts - a0, 10);
    drain();

    // Reset mid-stream discards everything in flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(ALU_ADD, 1'b0, 32'd100, DW'(i), TW'(i));
      tick();
    end
    do_reset();
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    rsp_ready = 1'b1;
    send(ALU_ADD, 1'b0, 32'd1, 32'd1, 4'd7);
    tick();
    idle();
    tick();
    chk("mid_rst_first_valid", rsp_valid, 1);
    chk("mid_rst_first_y", rsp_y, 2);
    drain();

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] ra;
      ra = $urandom;
      send(alu_op_e'($urandom_range(0, 3)), ($urandom % 4) == 0, ra,
           (($urandom % 4) == 0) ? ra : DW'($urandom), TW'($urandom));
      cmd_valid = ($urandom % 4) != 0;
      rsp_ready = ($urandom % 3) != 0;
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
